wr_port_arbiter: RTL and testbench
==================================

WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

Interface
REQ-001 Parameter: DATA_W, default 64, width of write data per requester.
REQ-002 Parameter: NREQ, fixed value 4, number of write requesters; other values not supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: req  input  4  per-requester write request; bit i = requester i.
REQ-006 Port: req_addr  input  12  packed 3-bit register addresses; requester i uses bits [3i+2:3i].
REQ-007 Port: req_data  input  4*DATA_W  packed write data; requester i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-008 Port: stall  input  1  register file cannot accept a write this cycle.
REQ-009 Port: gnt  output  4  registered one-hot grant acknowledge, at most one bit high.
REQ-010 Port: dec_in  output  3  register address to the 3-to-8 write-enable decoder.
REQ-011 Port: dec_enable  output  1  decoder enable; high = one register written this cycle.
REQ-012 Port: wr_data  output  DATA_W  write data presented with dec_in/dec_enable.

Function
REQ-013 Block shall be a two-state FSM: IDLE (dec_enable low) and ISSUE (dec_enable high for exactly the granted write).
REQ-014 On a rising edge with stall low and req nonzero, block shall select one requester round-robin, starting at index ptr and ascending modulo 4.
REQ-015 Selected requester i shall see gnt[i]=1, dec_in=its addr, wr_data=its data, dec_enable=1, all registered, visible the cycle after req sampled (latency 1).
REQ-016 After granting i, ptr shall become (i+1) mod 4; ptr unchanged when no grant.
REQ-017 A requester shall hold req, addr and data stable until it observes gnt; request deasserted before grant is dropped with no side effects.
REQ-018 Back-to-back grants allowed: with continuous requests, one write per cycle, dec_enable stays high, gnt rotates.
REQ-019 gnt shall be a one-cycle pulse per granted write; requester still holding req after gnt is treated as a new request.
REQ-020 With stall high at an edge: no new grant, gnt=0, dec_enable=0, dec_in and wr_data hold previous values, ptr unchanged.
REQ-021 With req=0 and stall low: FSM goes IDLE, gnt=0, dec_enable=0, dec_in/wr_data hold.
REQ-022 Stall asserted in ISSUE cycle shall not cancel the write already presented; stall only blocks the next grant.
REQ-023 ptr wrap-around: grant at index 3 sets ptr=0.

Reset
REQ-024 reset high at an edge shall force: state IDLE, ptr=0, gnt=0, dec_enable=0, dec_in=0, wr_data=0.
REQ-025 reset shall override req and stall in the same cycle; a write in ISSUE when reset asserts is aborted, never extended.
REQ-026 First possible grant is the edge after the first edge with reset low.

Configuration
REQ-027 Macro WR_ARB_R0_BLOCK_EN: when defined, a granted request with addr 0 shall raise gnt normally and advance ptr, but dec_enable shall stay 0 (register 0 hardwired, write discarded).
REQ-028 Without WR_ARB_R0_BLOCK_EN, address 0 shall be written like any other address.

Verification
REQ-029 Reset: hold reset 2 cycles with req=4'b1111 -> gnt=0, dec_enable=0, dec_in=0, wr_data=0; first grant after release is gnt=4'b0001.
REQ-030 Round robin: req=4'b1111 held 5 cycles, addrs 1,2,3,4 -> gnt 0001,0010,0100,1000,0001; dec_in 1,2,3,4,1; dec_enable high every cycle.
REQ-031 Pointer skip: after grant to requester 1, req=4'b0011 -> gnt=0001 (ptr=2 wraps to 0), then ptr=1.
REQ-032 Stall: req=4'b0100, stall=1 for 3 cycles -> gnt=0, dec_enable=0; stall drop -> gnt=0100 next cycle, dec_in=requester 2 addr, wr_data=its data.
REQ-033 Mid-write reset: reset asserted during ISSUE with req=4'b0010 -> next cycle dec_enable=0, ptr=0, gnt=0.
REQ-034 R0 block: requester 0 addr=0, data=0xDEAD -> with WR_ARB_R0_BLOCK_EN gnt=0001, dec_enable=0; without macro gnt=0001, dec_enable=1, dec_in=0, wr_data=0xDEAD.

Source files
------------

// File: rtl/wr_port_arbiter_if.sv
// Write-port bundle between NREQ requesters and the register-file write decoder.
// Latency: none, signal container only.
// Backpressure: stall from the register file; gnt back to the requesters.
interface wr_port_arbiter_if #(
  parameter int DATA_W = 64
);
  logic [3:0]          req;
  logic [11:0]         req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic                stall;
  logic [3:0]          gnt;
  logic [2:0]          dec_in;
  logic                dec_enable;
  logic [DATA_W-1:0]   wr_data;

  // requester / register-file side
  modport master (
    output req, req_addr, req_data, stall,
    input  gnt, dec_in, dec_enable, wr_data
  );

  // arbiter side
  modport slave (
    input  req, req_addr, req_data, stall,
    output gnt, dec_in, dec_enable, wr_data
  );
endinterface

// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter of 4 write requesters onto one register-file write port.
// Latency: 1 cycle from req sampled to registered gnt/dec_in/dec_enable/wr_data.
// Backpressure: stall blocks new grants (outputs hold, no enable); presented write is never cancelled.
// Optional build macro WR_ARB_R0_BLOCK_EN: grants to address 0 pulse gnt but never raise dec_enable.
module wr_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int NREQ   = 4
) (
  input  logic          clk,
  input  logic          reset,
  wr_port_arbiter_if.slave bus
);

  // IDLE: nothing written this cycle. ISSUE: dec_enable high for the granted write.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [2:0]          dec_in_q, dec_in_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                found;
  logic [1:0]          sel;
  logic [2:0]          sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                wr_allowed;

  // Round-robin pick: first active request at ptr, ptr+1, ... modulo 4.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        sel   = ptr_q + 2'(k);
      end
    end
  end

  assign sel_addr = bus.req_addr[3*sel +: 3];
  assign sel_data = bus.req_data[DATA_W*sel +: DATA_W];

  // Decide whether the winning request actually drives a register write.
  always_comb begin
`ifdef WR_ARB_R0_BLOCK_EN
    // Register 0 is hardwired: the grant is acknowledged but the write is dropped.
    wr_allowed = (sel_addr != 3'd0);
`else
    wr_allowed = 1'b1;
`endif
  end

  // Next state: grant on any request unless stalled; address/data hold when no write issues.
  always_comb begin
    state_d   = IDLE;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    dec_in_d  = dec_in_q;
    wr_data_d = wr_data_q;
    if (!bus.stall && found) begin
      gnt_d[sel] = 1'b1;
      ptr_d      = sel + 2'd1;
      if (wr_allowed) begin
        state_d   = ISSUE;
        dec_in_d  = sel_addr;
        wr_data_d = sel_data;
      end
    end
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_q     <= '0;
      dec_in_q  <= 3'd0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      dec_in_q  <= dec_in_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.dec_in     = dec_in_q;
  assign bus.dec_enable = (state_q == ISSUE);
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Scoreboard bench for wr_port_arbiter: directed vectors push expectations, a monitor compares.
// Latency: expectation pushed with each driven cycle is checked just after the following edge.
// Backpressure: stall vectors are part of the directed stimulus.
module tb_wr_port_arbiter;
  localparam int DATA_W = 64;

  logic clk;
  logic reset;

  wr_port_arbiter_if #(.DATA_W(DATA_W)) bus ();

  wr_port_arbiter #(.DATA_W(DATA_W), .NREQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        gnt;
    logic              en;
    logic [2:0]        din;
    logic [DATA_W-1:0] wd;
    bit                chk;
    int                id;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;

  // Monitor: after each rising edge, compare the DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt) begin
        errors++;
        $display("FAIL gnt v%0d: got %b expected %b", e.id, bus.gnt, e.gnt);
      end
      checks++;
      if (bus.dec_enable !== e.en) begin
        errors++;
        $display("FAIL dec_enable v%0d: got %b expected %b", e.id, bus.dec_enable, e.en);
      end
      if (e.chk) begin
        checks++;
        if (bus.dec_in !== e.din) begin
          errors++;
          $display("FAIL dec_in v%0d: got %0d expected %0d", e.id, bus.dec_in, e.din);
        end
        checks++;
        if (bus.wr_data !== e.wd) begin
          errors++;
          $display("FAIL wr_data v%0d: got %h expected %h", e.id, bus.wr_data, e.wd);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic [3:0] rq, input logic st,
                      input logic [3:0] eg, input logic ee, input logic [2:0] ed,
                      input logic [DATA_W-1:0] ew, input bit ck);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    bus.req   = rq;
    bus.stall = st;
    e.gnt = eg;
    e.en  = ee;
    e.din = ed;
    e.wd  = ew;
    e.chk = ck;
    e.id  = vec_id;
    vec_id++;
    q.push_back(e);
  endtask

  localparam logic [DATA_W-1:0] D0 = 64'h1000;
  localparam logic [DATA_W-1:0] D1 = 64'h1001;
  localparam logic [DATA_W-1:0] D2 = 64'h1002;
  localparam logic [DATA_W-1:0] D3 = 64'h1003;
  localparam logic [DATA_W-1:0] DD = 64'hDEAD;

  initial begin
    reset        = 1'b1;
    bus.req      = 4'b0000;
    bus.stall    = 1'b0;
    bus.req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.req_data = {D3, D2, D1, D0};

    // Reset held with all requesters active: everything stays zero.
    step(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 3'd0, '0, 1'b1);
    step(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 3'd0, '0, 1'b1);

    // Round robin from ptr=0, back-to-back, wrapping 3 -> 0.
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 3'd1, D0, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 3'd2, D1, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 3'd3, D2, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 3'd4, D3, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 3'd1, D0, 1'b1);

    // Pointer skip: grant 1 (ptr=2), then 0011 wraps to requester 0, then ptr=1 picks 1.
    step(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, D1, 1'b1);
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 3'd1, D0, 1'b1);
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 3'd2, D1, 1'b1);

    // No requests: idle, address/data hold.
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd2, D1, 1'b1);

    // Stall for 3 cycles, then grant requester 2.
    step(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 3'd2, D1, 1'b1);
    step(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 3'd2, D1, 1'b1);
    step(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 3'd2, D1, 1'b1);
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 3'd3, D2, 1'b1);

    // Grant requester 3 (ptr wraps to 0); stall during its issue cycle blocks only the next grant.
    step(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 3'd4, D3, 1'b1);
    step(1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 3'd4, D3, 1'b1);
    step(1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 3'd1, D0, 1'b1);

    // Reset in the middle of an issue cycle; afterwards ptr is 0 again.
    step(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, D1, 1'b1);
    step(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 3'd0, '0, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 3'd1, D0, 1'b1);

    // Requester 0 writing register 0.
    @(negedge clk);
    bus.req_addr = {3'd4, 3'd3, 3'd2, 3'd0};
    bus.req_data = {D3, D2, D1, DD};
    vec_id++;
    q.push_back('{gnt: 4'b0001, en: 1'b1, din: 3'd1, wd: D0, chk: 1'b1, id: vec_id - 1});
    bus.req = 4'b0001;
`ifdef WR_ARB_R0_BLOCK_EN
    q[q.size()-1].en  = 1'b0;
    q[q.size()-1].din = 3'd1;
    q[q.size()-1].wd  = D0;
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd1, D0, 1'b1);
`else
    q[q.size()-1].en  = 1'b1;
    q[q.size()-1].din = 3'd0;
    q[q.size()-1].wd  = DD;
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, DD, 1'b1);
`endif

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
